button_event_unit: RTL
======================

// Module: button_event_unit
// PURPOSE
//  Front end for the five board push-buttons: synchronises raw pad inputs, debounces each one,
//  and latches rising-edge press events into a sticky register that the CPU reads over the I/O bus.
//  Sits between the board pins and the CPU I/O decode inside computer.
//  Replaces per-button polling with clear-on-read event flags and a level view.
//  Raises an interrupt request while any event is pending.
// PARAMETERS
//  WIDTH    16  debounce counter width; a change is accepted after 2^WIDTH consecutive disagreeing samples
//  NUM_BTN  5   number of buttons; bit order {down,right,center,left,up} = [4:0]
// PORTS
//  clk       in   1        system clock; all logic is on the rising edge
//  reset     in   1        synchronous, active-high reset
//  enable    in   1        1 = debounce/event logic runs; 0 = logic frozen, bus reads still serviced
//  buttons   in   NUM_BTN  raw asynchronous button pads, active-high
//  rd_en     in   1        CPU read strobe, one cycle
//  rd_sel    in   1        0 = level register; 1 = event register (clear-on-read)
//  rd_data   out  16       read data, zero-extended, registered
//  level     out  NUM_BTN  debounced button state
//  irq       out  1        high while any event bit is set
// BEHAVIOUR
//  Reset (reset=1 at an edge): sync FFs, counters, level, events, rd_data and irq all go to 0. Reset overrides every other input.
//  Synchroniser: 2-FF per button (s1 <= buttons; s2 <= s1). It runs even when enable=0.
//  Debounce, per bit, only when enable=1:
//   - s2 == level: cnt <= 0.
//   - s2 != level, cnt != all-ones: cnt <= cnt+1.
//   - s2 != level, cnt == all-ones: level <= s2; cnt <= 0.
//   - Result: a raw change is accepted at the (2^WIDTH+2)th rising edge, counting the s1 capture as the 1st.
//   - Any agreeing sample before that restarts the count, so a glitch shorter than 2^WIDTH samples is never accepted.
//  Events: event[i] is set on the same edge that level[i] goes 0->1. A 1->0 transition sets no event.
//  Read (rd_en=1 at an edge):
//   - rd_data <= zero-extended level when rd_sel=0, or zero-extended event when rd_sel=1. Valid on the following cycle.
//   - rd_data holds its value when rd_en=0.
//   - Event read (rd_sel=1): event is cleared on the same edge, except bits whose rising edge occurs on that same edge.
//     Those bits stay set and are not lost; the set wins over the clear.
//   - Level read: no side effects.
//  irq: registered; irq = |event as of the current cycle. It deasserts the cycle after a clearing read if no new event arrived.
//  enable=0: cnt, level and event hold their values. Reads are still serviced and an event read still clears.
//  Reset mid-debounce: any partial count is discarded. A button held through reset is accepted as a fresh press after release of reset.
// TESTING (WIDTH=1 via defparam)
//  1. Reset, then buttons=5'b00001 held -> level=5'b00001 and event[0]=1 at the 4th edge after change; irq=1 the following cycle.
//  2. rd_en=1, rd_sel=1 -> next cycle rd_data=16'h0001, event=0, irq=0. A second read returns 16'h0000.
//  3. buttons[2] high for 1 cycle only -> level[2] stays 0; no event; irq stays 0.
//  4. Press button[3] timed so its level rises on the same edge as an event read -> that read returns the old events;
//     event[3] remains 1 afterwards; irq stays 1.
//  5. enable=0, press button[4] for 10 cycles -> level and event unchanged. enable=1 with the button held -> accepted after 2 more edges.
//  6. reset pulsed while button[1] has been held for 1 accepted sample -> all outputs 0. With the button still held,
//     level[1]=1 at the 4th edge after reset deasserts.

Source files
------------

// File: rtl/button_event_unit_if.sv
// CPU-side read bus of the button event unit.
// Carries the read strobe, register select, read data and interrupt.
interface button_event_unit_if;
  logic        rd_en;
  logic        rd_sel;
  logic [15:0] rd_data;
  logic        irq;

  modport master (
    output rd_en,
    output rd_sel,
    input  rd_data,
    input  irq
  );

  modport slave (
    input  rd_en,
    input  rd_sel,
    output rd_data,
    output irq
  );
endinterface

// File: rtl/button_event_unit.sv
// Push-button front end: 2-FF sync, per-bit debounce, sticky
// rising-edge events with clear-on-read, and an event interrupt.
module button_event_unit #(
    parameter int WIDTH   = 16,
    parameter int NUM_BTN = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_BTN-1:0] buttons,
    output logic [NUM_BTN-1:0] level,
    button_event_unit_if.slave bus
);

    logic [NUM_BTN-1:0] s1;
    logic [NUM_BTN-1:0] s2;
    logic [NUM_BTN-1:0] evt;
    logic [NUM_BTN-1:0] accept;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] evt_next;
    logic               clr;
    logic [WIDTH-1:0]   cnt [NUM_BTN];

    // A new rising edge on the clearing read edge survives the clear.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            accept[i] = enable && (s2[i] != level[i]) && (&cnt[i]);
        end
        rise     = accept & s2;
        clr      = bus.rd_en && bus.rd_sel;
        evt_next = (evt & ~{NUM_BTN{clr}}) | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= '0;
            s2          <= '0;
            level       <= '0;
            evt         <= '0;
            bus.irq     <= 1'b0;
            bus.rd_data <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= buttons;
            s2 <= s1;
            if (enable) begin
                for (int i = 0; i < NUM_BTN; i++) begin
                    if (s2[i] == level[i] || accept[i]) begin
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
            level   <= level ^ accept;
            evt     <= evt_next;
            bus.irq <= |evt_next;
            if (bus.rd_en) begin
                if (bus.rd_sel) begin
                    bus.rd_data <= {{(16-NUM_BTN){1'b0}}, evt};
                end else begin
                    bus.rd_data <= {{(16-NUM_BTN){1'b0}}, level};
                end
            end
        end
    end

endmodule
